// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the instruction step sequencer:
// state encoding and small state-classification helpers.
package riscv_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int INSTR_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } seq_state_e;

  // True while an instruction is in flight.
  function automatic logic state_is_busy(input seq_state_e st);
    logic b;
    case (st)
      ST_FETCH, ST_DECODE, ST_MEM, ST_COMMIT: b = 1'b1;
      default:                                b = 1'b0;
    endcase
    return b;
  endfunction

  // True in the states that wait on the UART bridge and are time-limited.
  function automatic logic state_is_timed(input seq_state_e st);
    logic t;
    case (st)
      ST_FETCH, ST_MEM: t = 1'b1;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_step_sequencer_if.sv
// Handshake between the step sequencer (master) and the UART bridge (slave):
// instruction fetch and data-memory transfer requests with their acks.
interface cpu_step_sequencer_if;
  import riscv_ctrl_pkg::*;

  logic               fetch_req;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic               mem_req;
  logic               mem_done;

  modport master (
    output fetch_req,
    output mem_req,
    input  instr_valid,
    input  instr_data,
    input  mem_done
  );

  modport slave (
    input  fetch_req,
    input  mem_req,
    output instr_valid,
    output instr_data,
    output mem_done
  );

endinterface

// File: rtl/step_timeout_timer.sv
// Wait-state watchdog: counts cycles while run is high and flags expiry on
// the TIMEOUT_CYCLES-th cycle since the last clear.
module step_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;
  logic          at_last_s;

  assign at_last_s = (count_r == LAST_CNT);
  assign expired   = run & at_last_s;

  // Cycle counter: restart on state entry, advance while waiting, hold at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (run && !at_last_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/cpu_step_sequencer.sv
// Instruction step sequencer: walks a multi-cycle datapath through
// FETCH/DECODE/MEM/COMMIT over a UART bridge, with halt, resume and a
// wait-state timeout. Optional feature macro STEP_CTRL_SINGLE_STEP_EN adds a
// step_req input that runs exactly one instruction out of HALT.
module cpu_step_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                read_enable,
  input  logic                write_enable,
`ifdef STEP_CTRL_SINGLE_STEP_EN
  input  logic                step_req,
`endif
  cpu_step_sequencer_if.master bus,
  output logic [INSTR_W-1:0]  instr_q,
  output logic                cpu_run,
  output logic                cpu_reset,
  output logic                busy,
  output logic                timeout_err,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    retired
);

  logic [1:0]         rst_sync_r;
  logic               rst_n_s;
  seq_state_e         state_r;
  seq_state_e         state_next;
  logic               halt_pending_r;
  logic               step_mode_r;
  logic               step_launch_s;
  logic               go_halt_s;
  logic               expired_s;
  logic               tmr_clear_s;
  logic               tmr_run_s;
  logic               fetch_req_r;
  logic               mem_req_r;
  logic               cpu_run_r;
  logic               cpu_reset_r;
  logic               busy_r;
  logic               timeout_err_r;
  logic [INSTR_W-1:0] instr_q_r;
  logic [CNT_W-1:0]   retired_r;

  // Reset assertion is immediate; release reaches the logic two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

`ifdef STEP_CTRL_SINGLE_STEP_EN
  assign step_launch_s = (state_r == ST_HALT) & ~start & step_req;
`else
  assign step_launch_s = 1'b0;
`endif

  // A halt seen in the commit cycle itself still stops at this boundary.
  assign go_halt_s   = halt_pending_r | halt_req | step_mode_r;
  assign tmr_clear_s = (state_next != state_r);
  assign tmr_run_s   = state_is_timed(state_r);

  step_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n_s),
    .clear   (tmr_clear_s),
    .run     (tmr_run_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; acks are checked before expiry so a same-cycle ack wins.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
        else       state_next = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.instr_valid) state_next = ST_DECODE;
        else if (expired_s)  state_next = ST_ERROR;
        else                 state_next = ST_FETCH;
      end
      ST_DECODE: begin
        if (read_enable || write_enable) state_next = ST_MEM;
        else                             state_next = ST_COMMIT;
      end
      ST_MEM: begin
        if (bus.mem_done)   state_next = ST_COMMIT;
        else if (expired_s) state_next = ST_ERROR;
        else                state_next = ST_MEM;
      end
      ST_COMMIT: begin
        if (go_halt_s) state_next = ST_HALT;
        else           state_next = ST_FETCH;
      end
      ST_HALT: begin
        if (start)              state_next = ST_FETCH;
        else if (step_launch_s) state_next = ST_FETCH;
        else                    state_next = ST_HALT;
      end
      ST_ERROR: begin
        if (start) state_next = ST_IDLE;
        else       state_next = ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sticky halt request, captured only while an instruction is in flight.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      halt_pending_r <= 1'b0;
    end else if (state_next == ST_HALT) begin
      halt_pending_r <= 1'b0;
    end else if (state_is_busy(state_r) && halt_req) begin
      halt_pending_r <= 1'b1;
    end else begin
      halt_pending_r <= halt_pending_r;
    end
  end

  // Single-step marker: the stepped instruction returns to HALT when it commits.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      step_mode_r <= 1'b0;
    end else if (state_next == ST_HALT || state_next == ST_IDLE) begin
      step_mode_r <= 1'b0;
    end else if (step_launch_s) begin
      step_mode_r <= 1'b1;
    end else begin
      step_mode_r <= step_mode_r;
    end
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      fetch_req_r   <= 1'b0;
      mem_req_r     <= 1'b0;
      cpu_run_r     <= 1'b0;
      cpu_reset_r   <= 1'b1;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      fetch_req_r   <= (state_next == ST_FETCH);
      mem_req_r     <= (state_next == ST_MEM);
      cpu_run_r     <= (state_next == ST_COMMIT);
      cpu_reset_r   <= (state_next == ST_IDLE);
      busy_r        <= state_is_busy(state_next);
      timeout_err_r <= (state_next == ST_ERROR);
    end
  end

  // Instruction latch, loaded only by an ack during FETCH.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      instr_q_r <= {INSTR_W{1'b0}};
    end else if (state_r == ST_FETCH && bus.instr_valid) begin
      instr_q_r <= bus.instr_data;
    end else begin
      instr_q_r <= instr_q_r;
    end
  end

  // Retired count steps with the commit strobe and wraps naturally.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (state_next == ST_COMMIT) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.fetch_req = fetch_req_r;
  assign bus.mem_req   = mem_req_r;
  assign cpu_run       = cpu_run_r;
  assign cpu_reset     = cpu_reset_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;
  assign instr_q       = instr_q_r;
  assign retired       = retired_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Self-checking bench for cpu_step_sequencer. Expected per-cycle behaviour is
// derived from an instruction timeline: each instruction occupies
// (fetch wait + 1) + 1 + (mem wait + 1 if memory) + 1 cycles.
module tb_cpu_step_sequencer;
  import riscv_ctrl_pkg::*;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          read_enable = 1'b0;
  logic          write_enable = 1'b0;
`ifdef STEP_CTRL_SINGLE_STEP_EN
  logic          step_req = 1'b0;
`endif
  logic [31:0]   instr_q;
  logic          cpu_run;
  logic          cpu_reset;
  logic          busy;
  logic          timeout_err;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int model_retired = 0;

  cpu_step_sequencer_if bus ();

  cpu_step_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt_req     (halt_req),
    .read_enable  (read_enable),
    .write_enable (write_enable),
`ifdef STEP_CTRL_SINGLE_STEP_EN
    .step_req     (step_req),
`endif
    .bus          (bus.master),
    .instr_q      (instr_q),
    .cpu_run      (cpu_run),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .state_o      (state_o),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {state_o, bus.fetch_req, bus.mem_req, cpu_run, busy, cpu_reset};
  endfunction

  function automatic logic [7:0] mk(input logic [2:0] st, input logic f, input logic m,
                                    input logic r, input logic b, input logic c);
    return {st, f, m, r, b, c};
  endfunction

  task automatic idle_inputs();
    start = 1'b0;
    halt_req = 1'b0;
    read_enable = 1'b0;
    write_enable = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_data = 32'h0;
    bus.mem_done = 1'b0;
`ifdef STEP_CTRL_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
  endtask

  // Drives one instruction from its first FETCH cycle; hk = cycle of a halt pulse or -1.
  task automatic run_instr(input bit mem, input bit wr, input int df, input int dm,
                           input int hk, input bit step, input logic [31:0] data,
                           input string tag);
    int lat;
    int mem_lo;
    int mem_hi;
    bit go_halt;
    logic [2:0] st;
    logic ef, em, er;
    lat = df + 3 + (mem ? dm + 1 : 0);
    mem_lo = df + 2;
    mem_hi = df + 2 + dm;
    go_halt = step || (hk >= 0 && hk < lat);
    for (int k = 0; k < lat; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= df)           st = 3'd1;
      else if (k == df + 1)  st = 3'd2;
      else if (k == lat - 1) st = 3'd4;
      else                   st = 3'd3;
      ef = (k <= df);
      em = mem && (k >= mem_lo) && (k <= mem_hi);
      er = (k == lat - 1);
      check_val({tag, "/cycle"}, {56'h0, out_vec()}, {56'h0, mk(st, ef, em, er, 1'b1, 1'b0)});
      if (k == lat - 1) begin
        model_retired = (model_retired + 1) % (1 << CW);
        check_val({tag, "/instr_q"}, {32'h0, instr_q}, {32'h0, data});
        check_val({tag, "/retired"}, {60'h0, retired}, 64'(model_retired));
      end
      bus.instr_valid = (k == df) ? 1'b1 : ((k > df) ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.instr_data = (k == df) ? data : $urandom();
      bus.mem_done = (mem && k == mem_hi) ||
                     ((!mem || k < mem_lo || k > mem_hi) && 1'($urandom_range(0, 1)));
      if (k == df + 1) begin
        read_enable = mem && !wr;
        write_enable = mem && wr;
      end else begin
        read_enable = 1'($urandom_range(0, 1));
        write_enable = 1'($urandom_range(0, 1));
      end
      halt_req = (k == hk);
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    idle_inputs();
    if (go_halt) check_val({tag, "/halted"}, {56'h0, out_vec()}, {56'h0, mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    else         check_val({tag, "/next"}, {56'h0, out_vec()}, {56'h0, mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)});
  endtask

  task automatic resume(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "/resume"}, {56'h0, out_vec()}, {56'h0, mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mem, wr;
    int df, dm, hk, lat;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_vec", {56'h0, out_vec()}, {56'h0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    check_val("reset_instr_q", {32'h0, instr_q}, 64'h0);
    check_val("reset_retired", {60'h0, retired}, 64'h0);
    check_val("reset_err", {63'h0, timeout_err}, 64'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_vec", {56'h0, out_vec()}, {56'h0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    resume("start");

    // Minimum latency, then a load with a 5-cycle memory wait.
    run_instr(1'b0, 1'b0, 0, 0, -1, 1'b0, 32'h0000_0013, "first");
    run_instr(1'b1, 1'b0, 0, 4, -1, 1'b0, 32'h0000_2083, "load5");

    // Halt requested during MEM, then noise in HALT that must be ignored.
    run_instr(1'b1, 1'b1, 1, 2, 4, 1'b0, 32'h0020_a023, "halt_mem");
    for (int i = 0; i < 4; i++) begin
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.mem_done = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("halt_hold", {61'h0, state_o}, 64'd5);
    end
    idle_inputs();
    resume("after_halt");

    // Acks on the last allowed cycle of both FETCH and MEM win over the timeout.
    run_instr(1'b1, 1'b0, TO - 1, TO - 1, -1, 1'b0, 32'hdead_beef, "ack_at_limit");

    // Randomized instruction stream; the retired counter wraps along the way.
    for (int n = 0; n < 40; n++) begin
      mem = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      df = int'($urandom_range(0, 3));
      dm = int'($urandom_range(0, 5));
      lat = df + 3 + (mem ? dm + 1 : 0);
      hk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      run_instr(mem, wr, df, dm, hk, 1'b0, $urandom(), "rand");
      if (hk >= 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        resume("rand");
      end
    end

    // FETCH timeout: no instruction ever arrives.
    for (int k = 0; k < TO; k++) begin
      check_val("to_wait", {56'h0, out_vec()}, {56'h0, mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)});
      bus.mem_done = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    idle_inputs();
    check_val("to_error_vec", {56'h0, out_vec()}, {56'h0, mk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
    check_val("to_error_flag", {63'h0, timeout_err}, 64'h1);
    check_val("to_retired", {60'h0, retired}, 64'(model_retired));
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check_val("to_sticky", {63'h0, timeout_err}, 64'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("to_clear_vec", {56'h0, out_vec()}, {56'h0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    check_val("to_clear_flag", {63'h0, timeout_err}, 64'h0);
    resume("after_error");

`ifdef STEP_CTRL_SINGLE_STEP_EN
    // Single step from HALT runs one instruction and comes back.
    run_instr(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h1111_0013, "pre_step");
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    check_val("step_launch", {61'h0, state_o}, 64'd1);
    run_instr(1'b1, 1'b0, 1, 1, -1, 1'b1, 32'h2222_2083, "step");
    resume("after_step");
`endif

    // Reset in the middle of a memory access aborts without a commit strobe.
    bus.instr_valid = 1'b1;
    bus.instr_data = 32'h0000_3003;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    check_val("rmid_in_mem", {56'h0, out_vec()}, {56'h0, mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)});
    #2 reset = 1'b0;
    #1;
    check_val("rmid_vec", {56'h0, out_vec()}, {56'h0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)});
    check_val("rmid_instr_q", {32'h0, instr_q}, 64'h0);
    check_val("rmid_retired", {60'h0, retired}, 64'h0);
    model_retired = 0;
    bus.mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rmid_no_run", {63'h0, cpu_run}, 64'h0);
    end
    bus.mem_done = 1'b0;

    // Release takes two edges to reach the sequencer; start held across it.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_val("rel_edge1", {61'h0, state_o}, 64'd0);
    @(negedge clk);
    check_val("rel_edge2", {61'h0, state_o}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check_val("rel_edge3", {61'h0, state_o}, 64'd1);
    run_instr(1'b0, 1'b0, 2, 0, -1, 1'b0, 32'h4444_0013, "post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
